timer_module: RTL and testbench

//  - Memory-mapped interval timer peripheral; the next slave on the I/O controller's bus (window 11'h030-11'h03f).
//  - Its readdata feeds the I/O controller's data_out mux; its interrupt output feeds the controller's interrupt vector.
//  - Prescaled up-counter with compare match, optional auto-reload and a maskable level interrupt.

---
 rtl/timer_pkg.sv | 30 +++
 rtl/timer_if.sv | 22 ++
 rtl/timer_prescaler.sv | 32 +++
 rtl/timer_module.sv | 149 ++++++++++++++
 tb/tb_timer_module.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - register offsets, CTRL bit positions and byte-merge helper for the interval timer
package timer_pkg;

    typedef enum logic [1:0] {
        TMR_CTRL    = 2'd0,
        TMR_COUNT   = 2'd1,
        TMR_COMPARE = 2'd2,
        TMR_CAPTURE = 2'd3
    } tmr_reg_e;

    localparam int CTRL_EN     = 0;
    localparam int CTRL_AR     = 1;
    localparam int CTRL_IE     = 2;
    localparam int CTRL_PS_LSB = 8;
    localparam int CTRL_CAPT   = 30;
    localparam int CTRL_EXP    = 31;

    // Replace only the bytes whose enable is set; the rest keep their old value.
    function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  be);
        logic [31:0] merged;
        merged = old_val;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) merged[8*i +: 8] = new_val[8*i +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/timer_if.sv
// rtl/timer_if.sv - I/O controller bus slave port of the interval timer
// Signals: read/write strobes, address (word select), data_in, be (byte enables),
//          data_out (read data), interrupt (level).
interface timer_if;
    logic        read;
    logic        write;
    logic [1:0]  address;
    logic [31:0] data_in;
    logic [3:0]  be;
    logic [31:0] data_out;
    logic        interrupt;

    modport master (
        output read, write, address, data_in, be,
        input  data_out, interrupt
    );

    modport slave (
        input  read, write, address, data_in, be,
        output data_out, interrupt
    );
endinterface

// File: rtl/timer_prescaler.sv
// rtl/timer_prescaler.sv - reloading down-counter producing the timer tick
// Ports: clk, rst_n (async active-low), prescale (reload value), enable,
//        clear (forces the divider to 0), tick (one-cycle pulse).
module timer_prescaler #(
    parameter int PRESCALE_BITS = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [PRESCALE_BITS-1:0] prescale,
    input  logic                     enable,
    input  logic                     clear,
    output logic                     tick
);

    logic [PRESCALE_BITS-1:0] cnt;

    // A cleared divider ticks on the first enabled cycle, then every prescale+1 cycles.
    assign tick = enable && (cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear || !enable) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= prescale;
        end else begin
            cnt <= cnt - PRESCALE_BITS'(1);
        end
    end

endmodule

// File: rtl/timer_module.sv
// rtl/timer_module.sv - memory-mapped prescaled interval timer with compare match
// Ports: clk, rst_n (async active-low), bus (timer_if.slave: read, write, address,
//        data_in, be, data_out, interrupt), capture_in (async capture pin).
// Build option: TIMER_CAPTURE_EN adds the synchronised capture pin, CAPTURE register
//        and CTRL[30] flag; without it capture_in is ignored and both read 0.
module timer_module
    import timer_pkg::*;
#(
    parameter int WIDTH         = 32,
    parameter int PRESCALE_BITS = 8
) (
    input  logic   clk,
    input  logic   rst_n,
    timer_if.slave bus,
    input  logic   capture_in
);

    logic                     ctrl_en, ctrl_ar, ctrl_ie;
    logic [PRESCALE_BITS-1:0] ctrl_ps;
    logic                     flag_exp, flag_capt;
    logic [WIDTH-1:0]         count_q, compare_q, capture_q;
    logic                     ctrl_wr, count_wr, compare_wr;
    logic                     tick, match;
    logic [31:0]              count_ext, compare_ext, capture_ext;
    logic [31:0]              count_wdata, compare_wdata, rdata;
    logic                     unused_read;

    // Reads are side-effect free, so the read strobe carries no information here.
    assign unused_read = bus.read;

    assign ctrl_wr    = bus.write && (bus.address == TMR_CTRL);
    assign count_wr   = bus.write && (bus.address == TMR_COUNT);
    assign compare_wr = bus.write && (bus.address == TMR_COMPARE);

    always_comb begin
        count_ext   = '0;
        compare_ext = '0;
        capture_ext = '0;
        count_ext[WIDTH-1:0]   = count_q;
        compare_ext[WIDTH-1:0] = compare_q;
        capture_ext[WIDTH-1:0] = capture_q;
    end

    assign count_wdata   = byte_merge(count_ext, bus.data_in, bus.be);
    assign compare_wdata = byte_merge(compare_ext, bus.data_in, bus.be);

    timer_prescaler #(.PRESCALE_BITS(PRESCALE_BITS)) u_prescaler (
        .clk      (clk),
        .rst_n    (rst_n),
        .prescale (ctrl_ps),
        .enable   (ctrl_en),
        .clear    (ctrl_wr),
        .tick     (tick)
    );

    assign match = tick && (count_q == compare_q);

    // CTRL and expired flag; a software enable write outranks the one-shot clear,
    // and a hardware set of expired outranks a same-cycle W1C.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_en  <= 1'b0;
            ctrl_ar  <= 1'b0;
            ctrl_ie  <= 1'b0;
            ctrl_ps  <= '0;
            flag_exp <= 1'b0;
        end else begin
            if (ctrl_wr && bus.be[0]) begin
                ctrl_en <= bus.data_in[CTRL_EN];
                ctrl_ar <= bus.data_in[CTRL_AR];
                ctrl_ie <= bus.data_in[CTRL_IE];
            end else if (match && !ctrl_ar) begin
                ctrl_en <= 1'b0;
            end
            if (ctrl_wr && bus.be[1]) begin
                ctrl_ps <= bus.data_in[CTRL_PS_LSB +: PRESCALE_BITS];
            end
            flag_exp <= match | (flag_exp & ~(ctrl_wr & bus.be[3] & bus.data_in[CTRL_EXP]));
        end
    end

    // COUNT: a software write outranks both increment and auto-reload.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q   <= '0;
            compare_q <= '0;
        end else begin
            if (count_wr) begin
                count_q <= count_wdata[WIDTH-1:0];
            end else if (tick) begin
                if (match) begin
                    if (ctrl_ar) count_q <= '0;
                end else begin
                    count_q <= count_q + WIDTH'(1);
                end
            end
            if (compare_wr) begin
                compare_q <= compare_wdata[WIDTH-1:0];
            end
        end
    end

`ifdef TIMER_CAPTURE_EN
    logic [2:0] cap_sync;
    logic       cap_edge;

    // Two flops for metastability, the third remembers the previous level.
    assign cap_edge = cap_sync[1] & ~cap_sync[2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_sync  <= '0;
            flag_capt <= 1'b0;
            capture_q <= '0;
        end else begin
            cap_sync  <= {cap_sync[1:0], capture_in};
            flag_capt <= cap_edge | (flag_capt & ~(ctrl_wr & bus.be[3] & bus.data_in[CTRL_CAPT]));
            if (cap_edge) capture_q <= count_q;
        end
    end
`else
    logic unused_capture_in;
    assign unused_capture_in = capture_in;
    assign flag_capt         = 1'b0;
    assign capture_q         = '0;
`endif

    always_comb begin
        rdata = '0;
        case (bus.address)
            TMR_CTRL: begin
                rdata[CTRL_EN]                        = ctrl_en;
                rdata[CTRL_AR]                        = ctrl_ar;
                rdata[CTRL_IE]                        = ctrl_ie;
                rdata[CTRL_PS_LSB +: PRESCALE_BITS]   = ctrl_ps;
                rdata[CTRL_CAPT]                      = flag_capt;
                rdata[CTRL_EXP]                       = flag_exp;
            end
            TMR_COUNT:   rdata = count_ext;
            TMR_COMPARE: rdata = compare_ext;
            TMR_CAPTURE: rdata = capture_ext;
            default:     rdata = '0;
        endcase
    end

    assign bus.data_out  = rdata;
    assign bus.interrupt = ctrl_ie & (flag_exp | flag_capt);

endmodule

// File: tb/tb_timer_module.sv
// tb/tb_timer_module.sv - table vectors, directed corner sequences and random stimulus for timer_module
module tb_timer_module;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic capture_in = 1'b0;
    logic pin = 1'b0;

    timer_if bus();

    timer_module #(.WIDTH(32), .PRESCALE_BITS(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .capture_in (capture_in)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state: register contents plus the number of enabled cycles
    // since the divider was last cleared, and the last three pin samples.
    logic        m_en, m_ar, m_ie, m_exp, m_capt;
    logic [7:0]  m_ps;
    logic [31:0] m_count, m_compare, m_capture;
    int          m_phase;
    logic        m_h1, m_h2, m_h3;

    typedef struct {
        logic        wr;
        logic [1:0]  a;
        logic [31:0] d;
        logic [3:0]  b;
        logic [31:0] exp_do;
        logic        exp_irq;
    } vec_t;

    vec_t tbl[16];

    task automatic check(input string tag, input string what, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s %s: got %h expected %h", tag, what, act, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d, input logic [3:0] b);
        logic [31:0] r;
        r = o;
        for (int i = 0; i < 4; i++) if (b[i]) r[8*i +: 8] = d[8*i +: 8];
        return r;
    endfunction

    task automatic m_reset();
        m_en = 0; m_ar = 0; m_ie = 0; m_exp = 0; m_capt = 0; m_ps = '0;
        m_count = '0; m_compare = '0; m_capture = '0; m_phase = 0;
        m_h1 = 0; m_h2 = 0; m_h3 = 0;
    endtask

    function automatic logic [31:0] m_read(input logic [1:0] a);
        case (a)
            2'd0:    return {m_exp, m_capt, 14'b0, m_ps, 5'b0, m_ie, m_ar, m_en};
            2'd1:    return m_count;
            2'd2:    return m_compare;
            default: return m_capture;
        endcase
    endfunction

    function automatic logic m_irq();
        return m_ie & (m_exp | m_capt);
    endfunction

    task automatic m_step(input logic wr, input logic [1:0] a, input logic [31:0] d, input logic [3:0] b);
        logic tick, match, ctrl_wr, edge_det;
        ctrl_wr  = wr && (a == 2'd0);
        tick     = m_en && ((m_phase % (int'(m_ps) + 1)) == 0);
        match    = tick && (m_count == m_compare);
        edge_det = 1'b0;
`ifdef TIMER_CAPTURE_EN
        edge_det = m_h2 && !m_h3;
`endif
        if (edge_det) m_capture = m_count;
        m_capt = edge_det || (m_capt && !(ctrl_wr && b[3] && d[30]));
        m_exp  = match || (m_exp && !(ctrl_wr && b[3] && d[31]));
        if (ctrl_wr || !m_en) m_phase = 0;
        else m_phase++;
        if (wr && a == 2'd1) m_count = merge(m_count, d, b);
        else if (tick) m_count = match ? (m_ar ? 32'd0 : m_count) : m_count + 32'd1;
        if (wr && a == 2'd2) m_compare = merge(m_compare, d, b);
        if (ctrl_wr && b[0]) m_en = d[0];
        else if (match && !m_ar) m_en = 1'b0;
        if (ctrl_wr && b[0]) begin
            m_ar = d[1];
            m_ie = d[2];
        end
        if (ctrl_wr && b[1]) m_ps = d[15:8];
        m_h3 = m_h2;
        m_h2 = m_h1;
        m_h1 = pin;
    endtask

    // Called just after a rising edge: drive, check at the falling edge, advance the model.
    task automatic apply(input logic wr, input logic [1:0] a, input logic [31:0] d, input logic [3:0] b,
                         input logic [31:0] exp_do, input logic exp_irq, input string tag);
        bus.read    = !wr;
        bus.write   = wr;
        bus.address = a;
        bus.data_in = d;
        bus.be      = b;
        capture_in  = pin;
        @(negedge clk);
        check(tag, "data_out", bus.data_out, exp_do);
        check(tag, "interrupt", {31'b0, bus.interrupt}, {31'b0, exp_irq});
        m_step(wr, a, d, b);
        @(posedge clk);
        #1;
    endtask

    task automatic mcyc(input logic wr, input logic [1:0] a, input logic [31:0] d, input logic [3:0] b, input string tag);
        apply(wr, a, d, b, m_read(a), m_irq(), tag);
    endtask

    initial begin
        logic [31:0] rd;
        logic [1:0]  ra;
        logic [3:0]  rb;
        logic        rw;

        tbl[0]  = '{1'b0, 2'd0, 32'h0,         4'h0, 32'h0,         1'b0};
        tbl[1]  = '{1'b0, 2'd1, 32'h0,         4'h0, 32'h0,         1'b0};
        tbl[2]  = '{1'b0, 2'd3, 32'h0,         4'h0, 32'h0,         1'b0};
        tbl[3]  = '{1'b1, 2'd2, 32'h5,         4'hF, 32'h0,         1'b0};
        tbl[4]  = '{1'b0, 2'd2, 32'h0,         4'h0, 32'h5,         1'b0};
        tbl[5]  = '{1'b1, 2'd0, 32'h5,         4'hF, 32'h0,         1'b0};
        tbl[6]  = '{1'b0, 2'd1, 32'h0,         4'h0, 32'h0,         1'b0};
        tbl[7]  = '{1'b0, 2'd1, 32'h0,         4'h0, 32'h1,         1'b0};
        tbl[8]  = '{1'b0, 2'd1, 32'h0,         4'h0, 32'h2,         1'b0};
        tbl[9]  = '{1'b0, 2'd1, 32'h0,         4'h0, 32'h3,         1'b0};
        tbl[10] = '{1'b0, 2'd1, 32'h0,         4'h0, 32'h4,         1'b0};
        tbl[11] = '{1'b0, 2'd1, 32'h0,         4'h0, 32'h5,         1'b0};
        tbl[12] = '{1'b0, 2'd1, 32'h0,         4'h0, 32'h5,         1'b1};
        tbl[13] = '{1'b0, 2'd0, 32'h0,         4'h0, 32'h8000_0004, 1'b1};
        tbl[14] = '{1'b1, 2'd0, 32'h8000_0000, 4'hF, 32'h8000_0004, 1'b1};
        tbl[15] = '{1'b0, 2'd0, 32'h0,         4'h0, 32'h0,         1'b0};

        bus.read = 0; bus.write = 0; bus.address = 0; bus.data_in = 0; bus.be = 0;
        m_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        m_step(1'b0, 2'd0, 32'h0, 4'h0);
        @(posedge clk);
        #1;

        // Reset state and one-shot run from the table.
        for (int i = 0; i < 16; i++)
            apply(tbl[i].wr, tbl[i].a, tbl[i].d, tbl[i].b, tbl[i].exp_do, tbl[i].exp_irq, "oneshot");

        // Auto-reload with prescale 2: count 0,1,2,3,0 with a tick every third cycle.
        mcyc(1'b1, 2'd2, 32'h3, 4'hF, "ar_setup");
        mcyc(1'b1, 2'd1, 32'h0, 4'hF, "ar_setup");
        mcyc(1'b1, 2'd0, 32'h0000_0207, 4'hF, "ar_setup");
        for (int k = 1; k <= 26; k++) begin
            logic [31:0] want;
            want = (k == 1) ? 32'd0 : 32'(((k - 2) / 3 + 1) % 4);
            apply(1'b0, 2'd1, 32'h0, 4'h0, want, (k > 10), "autoreload");
        end

        // W1C of expired colliding with a match, then COUNT write colliding with a tick.
        mcyc(1'b1, 2'd0, 32'h8000_0000, 4'hF, "coll_setup");
        mcyc(1'b1, 2'd1, 32'h0, 4'hF, "coll_setup");
        mcyc(1'b1, 2'd2, 32'h2, 4'hF, "coll_setup");
        mcyc(1'b1, 2'd0, 32'h7, 4'hF, "coll_setup");
        apply(1'b0, 2'd1, 32'h0, 4'h0, 32'h0, 1'b0, "coll_run");
        apply(1'b0, 2'd1, 32'h0, 4'h0, 32'h1, 1'b0, "coll_run");
        apply(1'b1, 2'd0, 32'h8000_0000, 4'b1000, 32'h0000_0007, 1'b0, "w1c_vs_match");
        apply(1'b0, 2'd0, 32'h0, 4'h0, 32'h8000_0007, 1'b1, "w1c_vs_match");
        apply(1'b1, 2'd1, 32'h100, 4'hF, 32'h1, 1'b1, "count_wr_vs_tick");
        apply(1'b0, 2'd1, 32'h0, 4'h0, 32'h100, 1'b1, "count_wr_vs_tick");

        // Byte enables on COUNT.
        mcyc(1'b1, 2'd0, 32'h8000_0000, 4'hF, "be_setup");
        mcyc(1'b1, 2'd1, 32'h0, 4'hF, "be_setup");
        mcyc(1'b1, 2'd1, 32'hAABB_CCDD, 4'b0010, "be_setup");
        apply(1'b0, 2'd1, 32'h0, 4'h0, 32'h0000_CC00, 1'b0, "byte_enable");

        // Capture pin rising while COUNT=7.
        mcyc(1'b1, 2'd1, 32'h0, 4'hF, "cap_setup");
        mcyc(1'b1, 2'd2, 32'hFFFF, 4'hF, "cap_setup");
        mcyc(1'b1, 2'd0, 32'h1, 4'hF, "cap_setup");
        for (int k = 1; k <= 10; k++) begin
            if (k == 8) pin = 1'b1;
            mcyc(1'b0, 2'd1, 32'h0, 4'h0, "cap_run");
        end
`ifdef TIMER_CAPTURE_EN
        apply(1'b0, 2'd3, 32'h0, 4'h0, 32'd9, 1'b0, "capture_reg");
        apply(1'b0, 2'd0, 32'h0, 4'h0, 32'h4000_0001, 1'b0, "capture_flag");
`else
        apply(1'b0, 2'd3, 32'h0, 4'h0, 32'd0, 1'b0, "capture_reg");
        apply(1'b0, 2'd0, 32'h0, 4'h0, 32'h0000_0001, 1'b0, "capture_flag");
`endif

        // Reset asserted mid-count with the interrupt pending.
        pin = 1'b0;
        mcyc(1'b1, 2'd1, 32'h0, 4'hF, "rst_setup");
        mcyc(1'b1, 2'd2, 32'h0, 4'hF, "rst_setup");
        mcyc(1'b1, 2'd0, 32'h7, 4'hF, "rst_setup");
        for (int k = 0; k < 3; k++) mcyc(1'b0, 2'd1, 32'h0, 4'h0, "rst_setup");
        bus.read = 1'b1; bus.write = 1'b0; bus.address = 2'd0;
        #2;
        rst_n = 1'b0;
        #1;
        check("reset", "interrupt", {31'b0, bus.interrupt}, 32'h0);
        for (int a = 0; a < 4; a++) begin
            bus.address = 2'(a);
            #1;
            check("reset", "data_out", bus.data_out, 32'h0);
        end
        rst_n = 1'b1;
        m_reset();
        m_step(1'b0, 2'd3, 32'h0, 4'h0);
        @(posedge clk);
        #1;

        // Randomised traffic against the model.
        for (int n = 0; n < 1500; n++) begin
            rw = ($urandom_range(0, 99) < 30);
            ra = 2'($urandom_range(0, 3));
            rb = 4'($urandom_range(0, 15));
            rd = $urandom;
            if (ra == 2'd0) begin
                rd[15:8] = 8'($urandom_range(0, 3));
                if ($urandom_range(0, 1) == 1) rd[0] = 1'b1;
            end else if ($urandom_range(0, 4) != 0) begin
                rd = 32'($urandom_range(0, 12));
            end
            if ($urandom_range(0, 9) == 0) pin = ~pin;
            if (rw) mcyc(1'b1, ra, rd, rb, "random");
            else    mcyc(1'b0, ra, 32'h0, 4'h0, "random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
